syrup_channel_fifo: RTL and testbench
=====================================

# syrup_channel_fifo

Concrete buffer behind a `SyrupOutChannel`/`SyrupInChannel` pair that share the same DOMAIN and ID.
- Stores words pushed by the producer-side user logic and returns them in FIFO order to the consumer-side user logic.
- Produces a `STALL` request that the domain clock-gating controller uses to freeze user logic when an access cannot complete this cycle.
- Sits directly downstream of the abstract channel ports and replaces them at substitution time.

## Interface
- `DATA_WIDTH`, 32, channel word width
- `ADDR_WIDTH`, 4, log2 of buffer depth; depth = 2^ADDR_WIDTH entries
- `CLK` in 1: single clock, rising edge
- `RESETN` in 1: asynchronous assert, active-low reset
- `D` in DATA_WIDTH: producer write data
- `WE` in 1: producer write request
- `FULL` out 1: buffer holds 2^ADDR_WIDTH words
- `Q` out DATA_WIDTH: consumer read data, registered
- `RE` in 1: consumer read request
- `EMPTY` out 1: buffer holds 0 words
- `COUNT` out ADDR_WIDTH+1: current occupancy
- `STALL` out 1: an access was refused this cycle; the domain must freeze

## Operation
- Storage: 2^ADDR_WIDTH-entry array, plus write pointer and read pointer (ADDR_WIDTH bits each, wrapping modulo depth) and COUNT.
- Acceptance is computed from the current-cycle registered state only:
  - push_ok = WE & !FULL
  - pop_ok = RE & !EMPTY
- push_ok: mem[wptr] <= D; wptr increments.
- pop_ok: Q <= mem[rptr]; rptr increments.
- Not pop_ok: Q holds its value.
- COUNT update: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- FULL = (COUNT == 2^ADDR_WIDTH). EMPTY = (COUNT == 0). Both are decoded from the registered COUNT.
- STALL = (WE & FULL) | (RE & EMPTY). Combinational.
- A refused access has no side effect. The frozen user logic re-presents the same WE/D or RE, which succeeds once space or data becomes available.
- Full with WE & RE:
  - The pop is accepted and the push is refused; STALL=1.
  - The next cycle, with FULL=0, the push is accepted.
- Empty with WE & RE:
  - The push is accepted and the pop is refused; STALL=1.
  - There is no write-to-read bypass.
- Reset is asynchronous, applied at any time, and discards the contents. Reset values:
  - wptr=0, rptr=0, COUNT=0, Q=0, FULL=0, EMPTY=1.
  - STALL follows its equation, so it equals RE while EMPTY=1.

## Timing
- Write-to-read latency: a word pushed at edge N is poppable at edge N+1. Its data appears on Q after the popping edge.
- Read latency: 1 cycle. Q is valid in the cycle after the RE cycle in which pop_ok was true.
- FULL, EMPTY and COUNT change only on clock edges, or asynchronously to their reset values.
- Sustained throughput: 1 push and 1 pop per cycle whenever 0 < COUNT < depth.

## Configuration
- `SYRUP_CHANNEL_STAT_EN` defined:
  - Adds outputs `STAT_PUSH` (32 bits), `STAT_POP` (32 bits) and `STAT_STALL` (32 bits).
  - Each counts, respectively: accepted pushes, accepted pops, and cycles with STALL=1.
  - The counters saturate at all-ones and reset to 0 on RESETN.
- Undefined: these ports and their counters do not exist. Core behaviour is identical in both builds.

## Structure
- Shared package `syrup_pkg`:
  - stat counter width constant (32)
  - channel occupancy typedef parameterised by ADDR_WIDTH
- One sub-module, `syrup_channel_ram`: simple dual-port RAM with one write port and one registered read port, inferable as block RAM.
- Pointers, COUNT, flags, stall logic and stat counters stay in the top-level module.

## Test plan
- Reset then idle, with RE=1 after reset:
  - EMPTY=1, FULL=0, COUNT=0, Q=0.
  - STALL=1 every cycle; no pointer moves.
- Fill an ADDR_WIDTH=2 FIFO with 0x11, 0x22, 0x33, 0x44, then present WE with 0x55:
  - FULL=1, COUNT=4.
  - The fifth write gives STALL=1 and COUNT stays 4.
  - One pop returns 0x11; the retried 0x55 is then accepted.
- Drain to empty:
  - Q sequence is 0x22, 0x33, 0x44, 0x55, each one cycle after its RE.
  - A further RE gives STALL=1 and Q holds 0x55.
- Empty with WE=1, RE=1, D=0xAB:
  - That cycle: push accepted, STALL=1, COUNT becomes 1.
  - Retried RE on the next cycle yields Q=0xAB, with no STALL.
- Steady stream: 100 cycles of WE & RE with COUNT=2:
  - COUNT stays 2 and STALL=0 throughout.
  - Data is in order across pointer wrap.
- Assert RESETN low mid-stream with COUNT=3: immediately COUNT=0, EMPTY=1, Q=0.
  - With `SYRUP_CHANNEL_STAT_EN`: all STAT_* outputs = 0 after reset.

Source files
------------

// File: rtl/syrup_pkg.sv
// Shared definitions for the syrup channel buffers: stat counter width and
// channel occupancy types.
package syrup_pkg;

    localparam int unsigned SYRUP_STAT_WIDTH     = 32;
    localparam int unsigned SYRUP_DEF_ADDR_WIDTH = 4;

    typedef logic [SYRUP_STAT_WIDTH-1:0]   syrup_stat_t;
    typedef logic [SYRUP_DEF_ADDR_WIDTH:0] syrup_occ_t;

    // Saturating increment used by the optional activity counters.
    function automatic syrup_stat_t stat_inc(input syrup_stat_t v, input logic en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

endpackage

// File: rtl/syrup_channel_ram.sv
// Simple dual-port RAM: one write port, one enabled registered read port.
// The storage array maps onto block RAM; only the read register is reset.
module syrup_channel_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

    // NOTE: the array deliberately has no reset so it stays inferable as block RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rdata <= '0;
        end else if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/syrup_channel_fifo.sv
// FIFO buffer behind a syrup out/in channel pair, with a combinational STALL
// for the domain clock gate. Define SYRUP_CHANNEL_STAT_EN for activity counters.
module syrup_channel_fifo
    import syrup_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = SYRUP_DEF_ADDR_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RESETN,
    input  logic [DATA_WIDTH-1:0] D,
    input  logic                  WE,
    output logic                  FULL,
    output logic [DATA_WIDTH-1:0] Q,
    input  logic                  RE,
    output logic                  EMPTY,
    output logic [ADDR_WIDTH:0]   COUNT,
    output logic                  STALL
`ifdef SYRUP_CHANNEL_STAT_EN
    ,
    output syrup_stat_t           STAT_PUSH,
    output syrup_stat_t           STAT_POP,
    output syrup_stat_t           STAT_STALL
`endif
);

    typedef logic [ADDR_WIDTH:0] occ_t;
    localparam occ_t DEPTH = occ_t'(2**ADDR_WIDTH);

    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_rptr;
    occ_t                  r_count;
    logic                  w_push_ok;
    logic                  w_pop_ok;

    assign FULL      = (r_count == DEPTH);
    assign EMPTY     = (r_count == '0);
    assign COUNT     = r_count;
    assign w_push_ok = WE & ~FULL;
    assign w_pop_ok  = RE & ~EMPTY;
    assign STALL     = (WE & FULL) | (RE & EMPTY);

    // Read and write never share an address in one cycle: that would need
    // COUNT to be both 0 and full, so no collision handling is required.
    syrup_channel_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk     (CLK),
        .rst_n   (RESETN),
        .i_we    (w_push_ok),
        .i_waddr (r_wptr),
        .i_wdata (D),
        .i_re    (w_pop_ok),
        .i_raddr (r_rptr),
        .o_rdata (Q)
    );

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef SYRUP_CHANNEL_STAT_EN
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            STAT_PUSH  <= '0;
            STAT_POP   <= '0;
            STAT_STALL <= '0;
        end else begin
            STAT_PUSH  <= stat_inc(STAT_PUSH, w_push_ok);
            STAT_POP   <= stat_inc(STAT_POP, w_pop_ok);
            STAT_STALL <= stat_inc(STAT_STALL, STALL);
        end
    end
`endif

endmodule

// File: tb/tb_syrup_channel_fifo.sv
// Scoreboard bench for syrup_channel_fifo: a queue-based reference model feeds
// per-cycle expectations to a monitor that samples the DUT on the falling edge.
module tb_syrup_channel_fifo;

    localparam int DW    = 32;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          CLK = 1'b0;
    logic          RESETN;
    logic [DW-1:0] D;
    logic          WE;
    logic          RE;
    logic          FULL;
    logic          EMPTY;
    logic          STALL;
    logic [DW-1:0] Q;
    logic [AW:0]   COUNT;
`ifdef SYRUP_CHANNEL_STAT_EN
    logic [31:0]   STAT_PUSH;
    logic [31:0]   STAT_POP;
    logic [31:0]   STAT_STALL;
`endif

    syrup_channel_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .CLK    (CLK),
        .RESETN (RESETN),
        .D      (D),
        .WE     (WE),
        .FULL   (FULL),
        .Q      (Q),
        .RE     (RE),
        .EMPTY  (EMPTY),
        .COUNT  (COUNT),
        .STALL  (STALL)
`ifdef SYRUP_CHANNEL_STAT_EN
        ,
        .STAT_PUSH  (STAT_PUSH),
        .STAT_POP   (STAT_POP),
        .STAT_STALL (STAT_STALL)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        stall;
        int          count;
        logic [31:0] q;
        int          n_push;
        int          n_pop;
        int          n_stall;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_fifo[$];
    logic [31:0] model_q;
    int          m_push;
    int          m_pop;
    int          m_stall;
    int          n_vec = 0;
    int          n_err = 0;
    exp_t        mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: compares the DUT against one model expectation per cycle.
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("count", 64'(COUNT), 64'(mon_e.count));
            check("full",  64'(FULL),  64'(mon_e.count == DEPTH));
            check("empty", 64'(EMPTY), 64'(mon_e.count == 0));
            check("stall", 64'(STALL), 64'(mon_e.stall));
            check("q",     64'(Q),     64'(mon_e.q));
`ifdef SYRUP_CHANNEL_STAT_EN
            check("stat_push",  64'(STAT_PUSH),  64'(mon_e.n_push));
            check("stat_pop",   64'(STAT_POP),   64'(mon_e.n_pop));
            check("stat_stall", 64'(STAT_STALL), 64'(mon_e.n_stall));
`endif
        end
    end

    // One clock of stimulus: record what the model says the DUT shows this
    // cycle, then advance the model across the coming edge.
    task automatic cycle(input logic we, input logic re, input logic [31:0] d);
        exp_t e;
        bit   push_ok;
        bit   pop_ok;
        @(posedge CLK);
        #1;
        WE = we;
        RE = re;
        D  = d;
        push_ok   = we && (model_fifo.size() < DEPTH);
        pop_ok    = re && (model_fifo.size() > 0);
        e.stall   = (we && !push_ok) || (re && !pop_ok);
        e.count   = model_fifo.size();
        e.q       = model_q;
        e.n_push  = m_push;
        e.n_pop   = m_pop;
        e.n_stall = m_stall;
        exp_q.push_back(e);
        if (pop_ok)  model_q = model_fifo.pop_front();
        if (push_ok) model_fifo.push_back(d);
        m_push  += int'(push_ok);
        m_pop   += int'(pop_ok);
        m_stall += int'(e.stall);
    endtask

    task automatic model_reset();
        model_fifo.delete();
        model_q = '0;
        m_push  = 0;
        m_pop   = 0;
        m_stall = 0;
    endtask

    // Asynchronous reset between edges, checked immediately.
    task automatic mid_reset();
        @(negedge CLK);
        #2;
        RESETN = 1'b0;
        WE     = 1'b0;
        RE     = 1'b0;
        #1;
        check("rst_count", 64'(COUNT), 64'd0);
        check("rst_empty", 64'(EMPTY), 64'd1);
        check("rst_full",  64'(FULL),  64'd0);
        check("rst_q",     64'(Q),     64'd0);
        check("rst_stall", 64'(STALL), 64'd0);
`ifdef SYRUP_CHANNEL_STAT_EN
        check("rst_stat_push",  64'(STAT_PUSH),  64'd0);
        check("rst_stat_pop",   64'(STAT_POP),   64'd0);
        check("rst_stat_stall", 64'(STAT_STALL), 64'd0);
`endif
        model_reset();
        @(posedge CLK);
        #1;
        RESETN = 1'b1;
    endtask

    initial begin
        RESETN = 1'b0;
        WE     = 1'b0;
        RE     = 1'b1;
        D      = '0;
        model_reset();
        #3;
        check("init_count", 64'(COUNT), 64'd0);
        check("init_empty", 64'(EMPTY), 64'd1);
        check("init_full",  64'(FULL),  64'd0);
        check("init_q",     64'(Q),     64'd0);
        check("init_stall", 64'(STALL), 64'd1);
        RE = 1'b0;
        #14;
        RESETN = 1'b1;

        // Idle reads on an empty buffer.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, '0);

        // Fill, overflow attempt, pop-while-full, then retried push.
        cycle(1'b1, 1'b0, 32'h11);
        cycle(1'b1, 1'b0, 32'h22);
        cycle(1'b1, 1'b0, 32'h33);
        cycle(1'b1, 1'b0, 32'h44);
        cycle(1'b1, 1'b0, 32'h55);
        cycle(1'b1, 1'b1, 32'h55);
        cycle(1'b1, 1'b0, 32'h55);

        // Drain, then one read too many.
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, '0);
        cycle(1'b0, 1'b0, '0);

        // Push and pop together on empty: only the push lands.
        cycle(1'b1, 1'b1, 32'hAB);
        cycle(1'b0, 1'b1, '0);
        cycle(1'b0, 1'b0, '0);

        // Steady stream at occupancy 2 across pointer wrap.
        cycle(1'b1, 1'b0, $urandom);
        cycle(1'b1, 1'b0, $urandom);
        for (int i = 0; i < 100; i++) cycle(1'b1, 1'b1, $urandom);

        // Random traffic.
        for (int i = 0; i < 300; i++) cycle(1'($urandom_range(1)), 1'($urandom_range(1)), $urandom);

        // Reach occupancy 3 and reset while streaming.
        while (model_fifo.size() < 3) cycle(1'b1, 1'b0, $urandom);
        while (model_fifo.size() > 3) cycle(1'b0, 1'b1, '0);
        cycle(1'b1, 1'b1, $urandom);
        mid_reset();

        for (int i = 0; i < 40; i++) cycle(1'($urandom_range(1)), 1'($urandom_range(1)), $urandom);
        cycle(1'b0, 1'b0, '0);
        @(negedge CLK);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
